// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W     = 32;
    localparam int MEM_ARB_DATA_W     = 32;
    localparam int MEM_ARB_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data load/store port onto one
// single-outstanding memory interface, data first with bounded fetch starvation.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction outstanding; pick a requester
// BUSY_I | fetch issued on the memory port, waiting for m_ack
// BUSY_D | load/store issued on the memory port, waiting for m_ack
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ARB_ADDR_W,
    parameter int DATA_W     = MEM_ARB_DATA_W,
    parameter int STARVE_MAX = MEM_ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_instr_out,
    output logic              i_stall,

    input  logic              d_read_en,
    input  logic              d_write_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_write_data,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_stall,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [SW-1:0]     streak_q, streak_d;

    logic              d_any;
    logic              i_forced;

    assign d_any    = d_read_en | d_write_en;
    assign i_forced = i_read_en && (streak_q == STREAK_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            instr_q  <= '0;
            dout_q   <= '0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            instr_q  <= instr_d;
            dout_q   <= dout_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        instr_d  = instr_q;
        dout_d   = dout_q;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        streak_d = streak_q;

        case (state_q)
            IDLE: begin
                if (!i_read_en) begin
                    streak_d = '0;
                end
                // Priority is decided on the raw enables; a winner still showing
                // its done pulse is vetoed and nobody is granted this cycle.
                if (d_any && !i_forced) begin
                    if (!d_done_q) begin
                        state_d = BUSY_D;
                        addr_d  = d_addr;
                        wdata_d = d_write_data;
                        we_d    = d_write_en;
                        if (i_read_en) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end
                end else if (i_read_en && !i_done_q) begin
                    state_d  = BUSY_I;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    streak_d = '0;
                end
            end
            BUSY_I: begin
                if (m_ack) begin
                    instr_d  = m_rdata;
                    i_done_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            BUSY_D: begin
                if (m_ack) begin
                    if (!we_q) begin
                        dout_d = m_rdata;
                    end
                    d_done_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_req       = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign m_we        = we_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
    assign i_instr_out = instr_q;
    assign d_data_out  = dout_q;
    assign i_stall     = i_read_en & ~i_done_q;
    assign d_stall     = d_any & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read_en;
    logic [31:0] i_addr;
    logic [31:0] i_instr_out;
    logic        i_stall;
    logic        d_read_en;
    logic        d_write_en;
    logic [31:0] d_addr;
    logic [31:0] d_write_data;
    logic [31:0] d_data_out;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_read_en(i_read_en), .i_addr(i_addr), .i_instr_out(i_instr_out), .i_stall(i_stall),
        .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr),
        .d_write_data(d_write_data), .d_data_out(d_data_out), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_read_en = 0; i_addr = 0; d_read_en = 0; d_write_en = 0;
        d_addr = 0; d_write_data = 0; m_rdata = 0; m_ack = 0;
        tick(); tick();
        n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL rst_m_req got %0h exp 0", m_req); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("FAIL rst_m_we got %0h exp 0", m_we); end
        n_cmp++; if (m_addr !== 32'h0) begin n_bad++; $display("FAIL rst_m_addr got %08h exp 0", m_addr); end
        n_cmp++; if (m_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_m_wdata got %08h exp 0", m_wdata); end
        n_cmp++; if (i_instr_out !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %08h exp 0", i_instr_out); end
        n_cmp++; if (d_data_out !== 32'h0) begin n_bad++; $display("FAIL rst_dout got %08h exp 0", d_data_out); end
        rst = 1'b0;
        tick();
        n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL idle_m_req got %0h exp 0", m_req); end
        n_cmp++; if ({i_stall, d_stall} !== 2'b00) begin n_bad++; $display("FAIL idle_stalls got %b exp 00", {i_stall, d_stall}); end
    endtask

    task automatic test_fetch();
        i_read_en = 1'b1; i_addr = 32'h40;
        #1;
        n_cmp++; if (i_stall !== 1'b1) begin n_bad++; $display("FAIL fetch_stall0 got %0h exp 1", i_stall); end
        tick();
        n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL fetch_m_req got %0h exp 1", m_req); end
        n_cmp++; if (m_addr !== 32'h40) begin n_bad++; $display("FAIL fetch_m_addr got %08h exp 00000040", m_addr); end
        n_cmp++; if (m_we !== 1'b0) begin n_bad++; $display("FAIL fetch_m_we got %0h exp 0", m_we); end
        m_ack = 1'b1; m_rdata = 32'h2008000A;
        tick();
        m_ack = 1'b0;
        n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL fetch_m_req_drop got %0h exp 0", m_req); end
        n_cmp++; if (i_stall !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_done got %0h exp 0", i_stall); end
        n_cmp++; if (i_instr_out !== 32'h2008000A) begin n_bad++; $display("FAIL fetch_instr got %08h exp 2008000a", i_instr_out); end
        i_read_en = 1'b0;
        tick();
        n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL fetch_no_regrant got %0h exp 0", m_req); end
    endtask

    task automatic test_idle_ack();
        m_ack = 1'b1; m_rdata = 32'h12345678;
        tick();
        m_ack = 1'b0;
        tick();
        n_cmp++; if (i_instr_out !== 32'h2008000A) begin n_bad++; $display("FAIL idle_ack_instr got %08h exp 2008000a", i_instr_out); end
        n_cmp++; if (d_data_out !== 32'h0) begin n_bad++; $display("FAIL idle_ack_dout got %08h exp 0", d_data_out); end
        n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL idle_ack_m_req got %0h exp 0", m_req); end
    endtask

    task automatic test_dual();
        i_read_en = 1'b1; i_addr = 32'h80; d_read_en = 1'b1; d_addr = 32'h100;
        tick();
        n_cmp++; if (m_addr !== 32'h100) begin n_bad++; $display("FAIL dual_first_addr got %08h exp 00000100", m_addr); end
        n_cmp++; if ({m_req, m_we} !== 2'b10) begin n_bad++; $display("FAIL dual_first_req_we got %b exp 10", {m_req, m_we}); end
        n_cmp++; if ({i_stall, d_stall} !== 2'b11) begin n_bad++; $display("FAIL dual_busy_stalls got %b exp 11", {i_stall, d_stall}); end
        m_ack = 1'b1; m_rdata = 32'hCAFE0001;
        tick();
        m_ack = 1'b0;
        n_cmp++; if (d_data_out !== 32'hCAFE0001) begin n_bad++; $display("FAIL dual_dout got %08h exp cafe0001", d_data_out); end
        n_cmp++; if ({i_stall, d_stall} !== 2'b10) begin n_bad++; $display("FAIL dual_done_stalls got %b exp 10", {i_stall, d_stall}); end
        d_read_en = 1'b0;
        tick();
        n_cmp++; if ({m_req, m_addr} !== {1'b1, 32'h80}) begin n_bad++; $display("FAIL dual_second got req=%0h addr=%08h exp req=1 addr=00000080", m_req, m_addr); end
        n_cmp++; if (i_stall !== 1'b1) begin n_bad++; $display("FAIL dual_fetch_stall got %0h exp 1", i_stall); end
        m_ack = 1'b1; m_rdata = 32'h11110000;
        tick();
        m_ack = 1'b0;
        n_cmp++; if (i_instr_out !== 32'h11110000) begin n_bad++; $display("FAIL dual_instr got %08h exp 11110000", i_instr_out); end
        n_cmp++; if (d_data_out !== 32'hCAFE0001) begin n_bad++; $display("FAIL dual_dout_keep got %08h exp cafe0001", d_data_out); end
        i_read_en = 1'b0;
        tick();
    endtask

    task automatic test_write();
        d_write_en = 1'b1; d_addr = 32'h10; d_write_data = 32'hDEADBEEF;
        tick();
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h10, 32'hDEADBEEF}) begin
                n_bad++;
                $display("FAIL write_hold%0d got req=%0h we=%0h addr=%08h wdata=%08h exp 1 1 00000010 deadbeef",
                         c, m_req, m_we, m_addr, m_wdata);
            end
            d_addr = 32'h99; d_write_data = 32'h0;
            if (c == 3) begin
                m_ack = 1'b1; m_rdata = 32'h55555555;
            end
            tick();
        end
        m_ack = 1'b0;
        n_cmp++; if (d_data_out !== 32'hCAFE0001) begin n_bad++; $display("FAIL write_dout got %08h exp cafe0001", d_data_out); end
        n_cmp++; if (i_instr_out !== 32'h11110000) begin n_bad++; $display("FAIL write_instr got %08h exp 11110000", i_instr_out); end
        n_cmp++; if ({m_req, d_stall} !== 2'b00) begin n_bad++; $display("FAIL write_done got %b exp 00", {m_req, d_stall}); end
        d_write_en = 1'b0;
        tick();
    endtask

    task automatic test_read_and_write();
        d_read_en = 1'b1; d_write_en = 1'b1; d_addr = 32'h20; d_write_data = 32'h0BADF00D;
        tick();
        n_cmp++; if ({m_req, m_we, m_wdata} !== {1'b1, 1'b1, 32'h0BADF00D}) begin n_bad++; $display("FAIL rw_we got req=%0h we=%0h wdata=%08h exp 1 1 0badf00d", m_req, m_we, m_wdata); end
        m_ack = 1'b1; m_rdata = 32'h77777777;
        tick();
        m_ack = 1'b0;
        n_cmp++; if (d_data_out !== 32'hCAFE0001) begin n_bad++; $display("FAIL rw_dout got %08h exp cafe0001", d_data_out); end
        d_read_en = 1'b0; d_write_en = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        int  n_d;
        bit  got_i;
        n_d = 0; got_i = 0;
        i_read_en = 1'b1; i_addr = 32'h200; d_read_en = 1'b1; d_addr = 32'h300;
        for (int c = 0; c < 60 && !got_i; c++) begin
            if (m_req) begin
                if (m_addr == 32'h200) got_i = 1'b1;
                else n_d++;
                m_ack = 1'b1; m_rdata = 32'hA0000000 + 32'(c);
            end
            tick();
            m_ack = 1'b0;
        end
        i_read_en = 1'b0; d_read_en = 1'b0;
        n_cmp++; if (got_i !== 1'b1) begin n_bad++; $display("FAIL starve_timeout got fetch_granted=%0d exp 1", got_i); end
        n_cmp++; if (n_d !== 4) begin n_bad++; $display("FAIL starve_count got %0d data grants exp 4", n_d); end
        tick();
        n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL starve_quiet got %0h exp 0", m_req); end
    endtask

    task automatic test_reset_busy();
        d_read_en = 1'b1; d_addr = 32'h44;
        tick();
        n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL rstb_busy got %0h exp 1", m_req); end
        rst = 1'b1;
        tick();
        n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL rstb_m_req got %0h exp 0", m_req); end
        rst = 1'b0; d_read_en = 1'b0;
        m_ack = 1'b1; m_rdata = 32'hBADBAD00;
        tick();
        m_ack = 1'b0;
        tick();
        n_cmp++; if (d_data_out !== 32'h0) begin n_bad++; $display("FAIL rstb_dout got %08h exp 0", d_data_out); end
        n_cmp++; if ({m_req, d_stall} !== 2'b00) begin n_bad++; $display("FAIL rstb_idle got %b exp 00", {m_req, d_stall}); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_idle_ack();
        test_dual();
        test_write();
        test_read_and_write();
        test_starve();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
